// File: rtl/buff_pkg.sv
// buff_pkg: state encoding, default parameters and owner-id width helper for buff_rr_arbiter.
package buff_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
  localparam int MAX_BURST_DEF = 4;
  localparam int BUF_LAT_DEF = 1;
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/buff_rr_pick.sv
// buff_rr_pick: combinational round-robin picker, first set request scanning upward from ptr with wrap.
import buff_pkg::*;
module buff_rr_pick #(
  parameter int N = 4,
  parameter int IDW = id_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] id,
  output logic           any
);
  logic [2*N-1:0] dbl;
  assign dbl = {req, req} >> ptr;
  always_comb begin
    id = '0;
    for (int i = N - 1; i >= 0; i--)
      if (dbl[i]) id = IDW'((int'(ptr) + i) % N);
  end
  assign any = |req;
  assign onehot = any ? N'(1) << id : '0;
endmodule

// File: rtl/buff_rr_arbiter.sv
// buff_rr_arbiter: round-robin, burst-bounded sharing of one buff stage with a {valid,id} tag delay line.
// Optional BUFF_ARB_LOCK_EN adds a lock input that suspends the burst limit for the current owner.
import buff_pkg::*;
module buff_rr_arbiter #(
  parameter int N = 4,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int BUF_LAT = BUF_LAT_DEF,
  parameter int IDW = id_width(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   din,
`ifdef BUFF_ARB_LOCK_EN
  input  logic           lock,
`endif
  output logic [N-1:0]   gnt,
  output logic           buf_in,
  input  logic           buf_out,
  output logic           out_valid,
  output logic [IDW-1:0] out_id,
  output logic           out_data
);
  localparam logic [3:0] MB = 4'(MAX_BURST);
  state_t state, state_n;
  logic [IDW-1:0] own, own_n, ptr, ptr_n, nxt_own, p_ptr, p_id;
  logic [N-1:0] gnt_n, others, p_req, p_oh;
  logic [3:0] cnt, cnt_n;
  logic p_any, oth_any, keep, lk;
  logic [BUF_LAT-1:0] tv;
  logic [IDW-1:0] tid [BUF_LAT];
`ifdef BUFF_ARB_LOCK_EN
  assign lk = lock;
`else
  assign lk = 1'b0;
`endif
  assign others = req & ~gnt;
  assign oth_any = |others;
  assign nxt_own = (own == IDW'(N - 1)) ? '0 : own + 1'b1;
  // In GRANT the picker searches the competitors from the slot after the owner
  assign p_req = (state == GRANT) ? others : req;
  assign p_ptr = (state == GRANT) ? nxt_own : ptr;
  assign keep = req[own] && (lk || cnt < MB || !oth_any);
  buff_rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req(p_req), .ptr(p_ptr), .onehot(p_oh), .id(p_id), .any(p_any)
  );
  always_comb begin
    state_n = state;
    own_n = own;
    ptr_n = ptr;
    cnt_n = cnt;
    gnt_n = gnt;
    if (state == IDLE) begin
      if (p_any) begin
        state_n = GRANT;
        own_n = p_id;
        gnt_n = p_oh;
        cnt_n = 4'd1;
      end
    end else if (keep) begin
      cnt_n = (lk || cnt >= MB) ? MB : cnt + 4'd1;
    end else if (oth_any) begin
      ptr_n = nxt_own;
      own_n = p_id;
      gnt_n = p_oh;
      cnt_n = 4'd1;
    end else begin
      state_n = IDLE;
      gnt_n = '0;
      ptr_n = nxt_own;
      cnt_n = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      own <= '0;
      ptr <= '0;
      cnt <= '0;
      gnt <= '0;
    end else begin
      state <= state_n;
      own <= own_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      gnt <= gnt_n;
    end
  end
  assign buf_in = (state == GRANT) ? din[own] : 1'b0;
  always_ff @(posedge clk) begin
    if (reset) begin
      tv <= '0;
      for (int i = 0; i < BUF_LAT; i++) tid[i] <= '0;
    end else begin
      tv[0] <= (state == GRANT);
      tid[0] <= own;
      for (int i = 1; i < BUF_LAT; i++) begin
        tv[i] <= tv[i-1];
        tid[i] <= tid[i-1];
      end
    end
  end
  assign out_valid = tv[BUF_LAT-1];
  assign out_id = tid[BUF_LAT-1];
  assign out_data = buf_out;
endmodule

// File: tb/tb_buff_rr_arbiter.sv
// tb_buff_rr_arbiter: directed and random stimulus checked against a rule-level arbiter model.
module tb_buff_rr_arbiter;
  localparam int N = 4;
  localparam int MB = 4;
  localparam int BL = 1;
  localparam int IDW = 2;
  logic clk = 0, reset = 1;
  logic [N-1:0] req = '0, din = '0, gnt;
  logic buf_in, buf_out, out_valid, out_data;
  logic [IDW-1:0] out_id;
  logic [BL-1:0] bsh = '0;
  int n_chk = 0, n_pass = 0;
  int m_state = 0, m_own = 0, m_ptr = 0, m_cnt = 0;
  int ev[BL], eid[BL], ed[BL];
  always #5 clk = ~clk;
  always @(posedge clk) bsh <= (bsh << 1) | BL'(buf_in);
  assign buf_out = bsh[BL-1];
`ifdef BUFF_ARB_LOCK_EN
  logic lock = 1'b0;
`endif
  buff_rr_arbiter #(.N(N), .MAX_BURST(MB), .BUF_LAT(BL)) dut (
    .clk(clk), .reset(reset), .req(req), .din(din),
`ifdef BUFF_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt), .buf_in(buf_in), .buf_out(buf_out),
    .out_valid(out_valid), .out_id(out_id), .out_data(out_data)
  );
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask
  function automatic int first_from(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  task automatic cyc(input logic r, input logic [N-1:0] rq, input logic [N-1:0] d);
    bit other;
    reset = r;
    req = rq;
    din = d;
    #1;
    chk("gnt", int'(gnt), m_state ? (1 << m_own) : 0);
    chk("buf_in", int'(buf_in), m_state ? int'(d[m_own]) : 0);
    chk("out_valid", int'(out_valid), ev[BL-1]);
    if (ev[BL-1] != 0) begin
      chk("out_id", int'(out_id), eid[BL-1]);
      chk("out_data", int'(out_data), ed[BL-1]);
    end
    if (r) begin
      m_state = 0; m_own = 0; m_ptr = 0; m_cnt = 0;
      for (int i = 0; i < BL; i++) begin ev[i] = 0; eid[i] = 0; ed[i] = 0; end
    end else begin
      for (int i = BL - 1; i > 0; i--) begin ev[i] = ev[i-1]; eid[i] = eid[i-1]; ed[i] = ed[i-1]; end
      ev[0] = m_state; eid[0] = m_own; ed[0] = m_state ? int'(d[m_own]) : 0;
      if (m_state == 0) begin
        if (first_from(rq, m_ptr) >= 0) begin
          m_state = 1; m_own = first_from(rq, m_ptr); m_cnt = 1;
        end
      end else begin
        other = 0;
        for (int j = 0; j < N; j++) if (j != m_own && rq[j]) other = 1;
        if (rq[m_own] && (m_cnt < MB || !other)) m_cnt = (m_cnt < MB) ? m_cnt + 1 : MB;
        else if (other) begin
          m_ptr = (m_own + 1) % N; m_own = first_from(rq, m_ptr); m_cnt = 1;
        end else begin
          m_state = 0; m_ptr = (m_own + 1) % N; m_cnt = 0;
        end
      end
    end
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < BL; i++) begin ev[i] = 0; eid[i] = 0; ed[i] = 0; end
    repeat (2) @(negedge clk);
    cyc(1, '0, '0);
    repeat (5) cyc(0, 4'b0000, 4'($urandom));
    cyc(0, 4'b0010, 4'b0000);
    cyc(0, 4'b0010, 4'b0010);
    cyc(0, 4'b0010, 4'b0000);
    cyc(0, 4'b0010, 4'b0010);
    cyc(0, 4'b0000, 4'b0000);
    repeat (3) cyc(0, 4'b0000, 4'b0000);
    cyc(1, '0, '0);
    repeat (20) cyc(0, 4'b1111, 4'($urandom));
    repeat (3) cyc(0, 4'b0000, '0);
    repeat (10) cyc(0, 4'b0001, 4'($urandom));
    repeat (3) cyc(0, 4'b0000, 4'($urandom));
    repeat (10) cyc(0, 4'b0100, 4'($urandom));
    repeat (2) cyc(0, 4'b1111, 4'($urandom));
    cyc(1, 4'b1111, 4'($urandom));
    repeat (6) cyc(0, 4'b1111, 4'($urandom));
    for (int t = 0; t < 800; t++) begin
      if ($urandom_range(3) == 0) req = 4'($urandom);
      cyc($urandom_range(63) == 0, req, 4'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
